instr_fetch_prefetcher: RTL and testbench
=========================================

Name: instr_fetch_prefetcher

Overview:
- Wishbone B4 classic master that sits directly upstream of the instruction ROM and downstream of the core's PC/branch logic.
- Fetches sequential aligned instruction words from the ROM into a small in-order prefetch FIFO.
- Presents {pc, instruction} pairs to the decode stage with a valid/ready handshake.
- Discards stale words on a redirect (branch/jump/trap).

Parameters:
- ADDR_SIZE, 32, byte-address width of ADR_O, pc_o and redirect_pc_i.
- DATA_SIZE, 32, instruction word width; also the DAT_I width. The address increment per fetch is DATA_SIZE/8.
- DEPTH_LOG2, 2, log2 of FIFO entries (default 4 entries).
- RESET_PC, 0, first fetch address after reset; must be word-aligned.

Ports:
- CLK_I  in  1  clock; all state updates on the rising edge.
- RST_NI  in  1  asynchronous, active-low reset.
- CYC_O  out  1  Wishbone cycle.
- STB_O  out  1  Wishbone strobe.
- ADR_O  out  ADDR_SIZE  fetch byte address; low log2(DATA_SIZE/8) bits always 0.
- DAT_I  in  DATA_SIZE  read data from ROM; valid when ACK_I=1.
- ACK_I  in  1  transaction acknowledge, one-cycle pulse.
- redirect_i  in  1  flush and restart fetch.
- redirect_pc_i  in  ADDR_SIZE  new fetch address; low alignment bits are ignored (forced 0).
- instr_o  out  DATA_SIZE  FIFO head instruction.
- pc_o  out  ADDR_SIZE  FIFO head address.
- valid_o  out  1  FIFO non-empty.
- ready_i  in  1  consumer accepts the head this cycle.

Behaviour:
- Reset (RST_NI=0, asynchronous):
  - CYC_O=0, STB_O=0, ADR_O=RESET_PC, valid_o=0, FIFO empty, fetch_pc=RESET_PC, FSM=IDLE.
  - Reset mid-transaction abandons the bus immediately; any later ACK_I while in IDLE is ignored.
- FSM states: IDLE, REQ, DISCARD.
- IDLE:
  - If no redirect this cycle and (occupancy + 0) < 2**DEPTH_LOG2 -> REQ next cycle.
  - On entry to REQ: CYC_O=STB_O=1, ADR_O=fetch_pc.
- REQ:
  - CYC_O, STB_O and ADR_O are held stable until ACK_I is sampled high.
  - On ACK_I without redirect: push {fetch_pc, DAT_I} into the FIFO, fetch_pc += DATA_SIZE/8, deassert CYC_O/STB_O, -> IDLE.
  - Minimum one idle bus cycle between transactions.
  - On ACK_I with redirect the same cycle: data dropped, fetch_pc=redirect_pc_i, -> IDLE.
  - On redirect without ACK_I: fetch_pc=redirect_pc_i, -> DISCARD. The bus is not aborted; CYC_O/STB_O/ADR_O keep their old values.
- DISCARD:
  - Holds the bus until ACK_I, then drops DAT_I, deasserts, -> IDLE.
  - A further redirect in DISCARD only overwrites fetch_pc.
- Space check: a request is issued only if the FIFO has a free slot at issue time. Since only one request is outstanding, the slot is guaranteed at ACK.
- Wrap-around: fetch_pc increments modulo 2**ADDR_SIZE.
- FIFO:
  - In-order, 2**DEPTH_LOG2 entries.
  - valid_o = occupancy != 0; instr_o/pc_o come from head registers (no combinational path from DAT_I).
  - Pop when valid_o && ready_i.
  - Push and pop in the same cycle are both performed; occupancy is unchanged.
  - Push when full cannot occur; an assertion in simulation checks this.
- Redirect cycle (redirect_i=1):
  - FIFO is cleared at the edge; valid_o=0 the next cycle.
  - Pop in the same cycle is ignored (the consumer must treat the head as killed).
  - Push in the same cycle is suppressed.
- Latencies:
  - Reset release -> CYC_O=1 at the first rising edge.
  - ACK_I edge -> valid_o=1 at the next cycle when the FIFO was empty.
  - Redirect edge -> first new request one cycle later (from IDLE), or one cycle after ACK (from DISCARD).
- Steady-state throughput: one word per (ROM latency + 2) cycles.

Test Plan:
- Reset with RESET_PC=0x0 and a ROM preloaded with words 0x00000013, 0x00100093, 0x00200113, ready_i=1 -> ADR_O sequence 0x0, 0x4, 0x8 and outputs (pc_o, instr_o) = (0x0, 0x00000013), (0x4, 0x00100093), (0x8, 0x00200113) in order, with no duplicates or gaps.
- ready_i=0 for 40 cycles with DEPTH_LOG2=2 -> exactly 4 bus transactions (0x0–0xC), then CYC_O stays 0. Raise ready_i -> pc_o 0x0, 0x4, 0x8, 0xC, then fetch resumes at 0x10.
- Redirect to 0x41 while REQ to 0x8 is pending without ACK -> CYC_O held through ACK and that data dropped. Next request at ADR_O=0x40; first valid_o shows pc_o=0x40.
- Redirect to 0x100 in the same cycle as ACK_I for 0x4, with valid_o=1 and ready_i=1 -> FIFO empty next cycle, 0x4 never output, next ADR_O=0x100.
- Assert RST_NI=0 mid-transaction -> CYC_O/STB_O fall without waiting for a clock edge. A subsequent stray ACK_I pulse during IDLE produces no push (valid_o stays 0).
- fetch_pc=0xFFFFFFFC with ADDR_SIZE=32 -> after that fetch the next ADR_O=0x00000000.

Source files
------------

// File: rtl/instr_fetch_prefetcher.sv
// instr_fetch_prefetcher: Wishbone classic instruction fetcher feeding an in-order prefetch FIFO
module instr_fetch_prefetcher #(
  parameter int ADDR_SIZE = 32,
  parameter int DATA_SIZE = 32,
  parameter int DEPTH_LOG2 = 2,
  parameter logic [ADDR_SIZE-1:0] RESET_PC = '0
) (
  input  logic                 CLK_I,
  input  logic                 RST_NI,
  output logic                 CYC_O,
  output logic                 STB_O,
  output logic [ADDR_SIZE-1:0] ADR_O,
  input  logic [DATA_SIZE-1:0] DAT_I,
  input  logic                 ACK_I,
  input  logic                 redirect_i,
  input  logic [ADDR_SIZE-1:0] redirect_pc_i,
  output logic [DATA_SIZE-1:0] instr_o,
  output logic [ADDR_SIZE-1:0] pc_o,
  output logic                 valid_o,
  input  logic                 ready_i
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [ADDR_SIZE-1:0] STEP = ADDR_SIZE'(DATA_SIZE / 8);
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state_q, state_d;
  logic cyc_q, cyc_d;
  logic [ADDR_SIZE-1:0] adr_q, adr_d, fetch_pc_q, fetch_pc_d, redir_pc;
  logic [DEPTH_LOG2-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic [ADDR_SIZE+DATA_SIZE-1:0] mem_q [DEPTH];
  logic push, pop, issue, done;
  assign CYC_O = cyc_q;
  assign STB_O = cyc_q;
  assign ADR_O = adr_q;
  assign valid_o = cnt_q != '0;
  assign {pc_o, instr_o} = mem_q[rd_q];
  always_comb begin
    redir_pc = redirect_pc_i & ~(STEP - 1'b1);
    push = state_q == REQ && ACK_I && !redirect_i;
    pop = valid_o && ready_i && !redirect_i;
    issue = state_q == IDLE && !redirect_i && cnt_q < FULL;
    done = state_q != IDLE && ACK_I;
    state_d = issue ? REQ : done ? IDLE : (state_q == REQ && redirect_i) ? DISCARD : state_q;
    cyc_d = issue || (cyc_q && !done);
    adr_d = issue ? fetch_pc_q : adr_q;
    fetch_pc_d = redirect_i ? redir_pc : push ? fetch_pc_q + STEP : fetch_pc_q;
    wr_d = redirect_i ? '0 : wr_q + DEPTH_LOG2'(push);
    rd_d = redirect_i ? '0 : rd_q + DEPTH_LOG2'(pop);
    cnt_d = redirect_i ? '0 : cnt_q + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
  end
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_q <= IDLE;
      cyc_q <= 1'b0;
      adr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cyc_q <= cyc_d;
      adr_q <= adr_d;
      fetch_pc_q <= fetch_pc_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge CLK_I) begin
    if (push) mem_q[wr_q] <= {fetch_pc_q, DAT_I};
  end
  assert property (@(posedge CLK_I) disable iff (!RST_NI) !(push && cnt_q == FULL));
endmodule

// File: tb/tb_instr_fetch_prefetcher.sv
// tb_instr_fetch_prefetcher: randomized scoreboard bench for the instruction prefetcher
module tb_instr_fetch_prefetcher;
  typedef struct packed {logic [31:0] pc; logic [31:0] instr;} ent_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cyc, stb, ack = 1'b0, redirect_i = 1'b0, valid_o, ready_i = 1'b0;
  logic [31:0] adr, dat = '0, redirect_pc_i = '0, instr_o, pc_o;
  int n_checks = 0, n_errors = 0, n_txn = 0, fixed_lat = -1, wait_cnt = -1;
  ent_t exp_q[$];
  logic [31:0] seen[$];
  logic [31:0] next_fetch = '0, txn_adr = '0;
  bit stale = 0, prev_cyc = 0, man = 0, man_ack = 0, ok;
  always #5 clk = ~clk;
  instr_fetch_prefetcher dut (
    .CLK_I(clk), .RST_NI(rst_n), .CYC_O(cyc), .STB_O(stb), .ADR_O(adr), .DAT_I(dat), .ACK_I(ack),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .instr_o(instr_o), .pc_o(pc_o),
    .valid_o(valid_o), .ready_i(ready_i)
  );
  function automatic logic [31:0] rom(input logic [31:0] a);
    return a == 32'h0 ? 32'h00000013 : a == 32'h4 ? 32'h00100093 : a == 32'h8 ? 32'h00200113 :
           (a * 32'h9E3779B1) ^ 32'hC0DE0000;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      ack = 1'b0;
      wait_cnt = -1;
    end else if (man) begin
      ack = man_ack;
      dat = rom(adr);
      wait_cnt = -1;
    end else if (ack) ack = 1'b0;
    else if (cyc) begin
      if (wait_cnt < 0) wait_cnt = fixed_lat >= 0 ? fixed_lat : int'($urandom_range(3));
      if (wait_cnt == 0) begin
        ack = 1'b1;
        dat = rom(adr);
        wait_cnt = -1;
      end else wait_cnt--;
    end
  end
  always @(negedge clk) begin : mon
    ent_t e;
    if (!rst_n) begin
      check("rst_valid", valid_o, 0);
      check("rst_bus", {stb, cyc}, 0);
    end else begin
      check("valid", valid_o, exp_q.size() != 0);
      if (valid_o && ready_i && !redirect_i) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL extra_output: got pc %h expected no output", pc_o);
        end else begin
          e = exp_q.pop_front();
          check("pc", pc_o, e.pc);
          check("instr", instr_o, e.instr);
          seen.push_back(pc_o);
        end
      end
    end
  end
  always @(negedge clk) begin
    #1;
    if (!rst_n) begin
      exp_q.delete();
      next_fetch = '0;
      stale = 0;
      prev_cyc = 0;
      n_txn = 0;
    end else begin
      check("stb", stb, cyc);
      if (cyc && !prev_cyc) begin
        n_txn++;
        check("issue_adr", adr, next_fetch);
        check("issue_space", exp_q.size() < 4, 1);
        txn_adr = adr;
        stale = 0;
      end else if (cyc) check("adr_hold", adr, txn_adr);
      if (cyc && redirect_i) stale = 1;
      if (cyc && ack && !stale) begin
        exp_q.push_back({adr, rom(adr)});
        next_fetch += 32'd4;
      end
      if (redirect_i) begin
        exp_q.delete();
        next_fetch = redirect_pc_i & ~32'h3;
      end
      prev_cyc = cyc;
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    redirect_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", {cyc, stb, valid_o, adr}, 0);
    seen.delete();
    rst_n = 1'b1;
  endtask
  task automatic wait_adr(input logic [31:0] a, output bit found);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(posedge clk);
      #1;
      found = cyc && adr == a;
    end
    check($sformatf("wait_adr_%h", a), found, 1);
  endtask
  task automatic pulse_redirect(input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect_i = 1'b1;
    redirect_pc_i = pc;
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
  endtask
  initial begin
    ready_i = 1'b1;
    fixed_lat = 1;
    do_reset();
    @(posedge clk);
    #1;
    check("first_req", {cyc, adr}, {1'b1, 32'h0});
    repeat (20) @(posedge clk);
    for (int i = 0; i < 3; i++)
      check($sformatf("seq%0d", i), i < seen.size() ? seen[i] : 32'hDEADBEEF, 32'(4 * i));
    ready_i = 1'b0;
    fixed_lat = -1;
    do_reset();
    repeat (40) @(posedge clk);
    #1;
    check("full_txn_count", n_txn, 4);
    check("full_idle", {cyc, valid_o}, 2'b01);
    ready_i = 1'b1;
    repeat (40) @(posedge clk);
    for (int i = 0; i < 5; i++)
      check($sformatf("resume%0d", i), i < seen.size() ? seen[i] : 32'hDEADBEEF, 32'(4 * i));
    fixed_lat = 3;
    do_reset();
    wait_adr(32'h8, ok);
    redirect_i = 1'b1;
    redirect_pc_i = 32'h41;
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    check("discard_hold", {cyc, adr}, {1'b1, 32'h8});
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = valid_o;
    end
    check("redirect_first_pc", {ok, pc_o, instr_o}, {1'b1, 32'h40, rom(32'h40)});
    man = 1;
    man_ack = 0;
    ready_i = 1'b0;
    do_reset();
    wait_adr(32'h0, ok);
    man_ack = 1;
    @(posedge clk);
    #1;
    man_ack = 0;
    wait_adr(32'h4, ok);
    check("pre_flush_valid", valid_o, 1);
    man_ack = 1;
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 0;
    redirect_i = 1'b0;
    ready_i = 1'b0;
    check("flush_valid", valid_o, 0);
    man = 0;
    wait_adr(32'h100, ok);
    check("no_pop_on_redirect", seen.size(), 0);
    man = 1;
    ready_i = 1'b1;
    do_reset();
    @(posedge clk);
    #3;
    check("pre_async_cyc", cyc, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst", {cyc, stb}, 0);
    @(posedge clk);
    #1;
    man_ack = 1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    man_ack = 0;
    check("stray_ack_ignored", {valid_o, cyc}, 2'b01);
    @(posedge clk);
    #1;
    check("stray_ack_valid", valid_o, 0);
    man = 0;
    fixed_lat = -1;
    pulse_redirect(32'hFFFFFFF4);
    wait_adr(32'hFFFFFFFC, ok);
    wait_adr(32'h0, ok);
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk);
      #1;
      ready_i = 1'($urandom_range(1));
      redirect_i = $urandom_range(24) == 0;
      redirect_pc_i = $urandom;
    end
    @(posedge clk);
    #1;
    redirect_i = 1'b0;
    ready_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("drain_valid", valid_o, exp_q.size() != 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
